// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial bit-pattern detector.
// Detects a right-aligned pattern of 1..MAX_LEN bits in a valid-qualified
// serial stream, with overlapping or non-overlapping detection.
// Optional feature macro: SEQ_DETECT_PROG_CNT_EN adds a saturating match
// counter on the match_count port, cleared by cnt_clr.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int DEF_LEN = 4,
  parameter logic [MAX_LEN-1:0] DEF_PAT = 8'b0000_1011,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         inp_bit,
  input  logic                         inp_valid,
  input  logic                         overlap,
  input  logic                         pat_load,
  input  logic [MAX_LEN-1:0]           pat_value,
  input  logic [$clog2(MAX_LEN+1)-1:0] pat_len,
  input  logic                         cnt_clr,
  output logic                         seq_seen,
  output logic                         cfg_err
`ifdef SEQ_DETECT_PROG_CNT_EN
  ,
  output logic [CNT_W-1:0]             match_count
`endif
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_seqSeen;
  logic               r_cfgErr;

  logic [MAX_LEN-1:0] w_histNext;
  logic [LEN_W-1:0]   w_fillInc;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_accept;
  logic               w_match;
  logic               w_lenLegal;

  assign w_accept   = inp_valid & ~pat_load;
  assign w_histNext = {r_hist[MAX_LEN-2:0], inp_bit};
  assign w_fillInc  = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
  assign w_lenLegal = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));

  // Build the compare mask and decide whether the post-shift history matches
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
    w_match = w_accept && (w_fillInc >= r_len) &&
              ((w_histNext & w_mask) == (r_pat & w_mask));
  end

  // History, fill level, pattern registers, match pulse and sticky config error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pat     <= DEF_PAT;
      r_len     <= LEN_W'(DEF_LEN);
      r_seqSeen <= 1'b0;
      r_cfgErr  <= 1'b0;
    end else begin
      r_seqSeen <= w_match;
      if (pat_load) begin
        if (w_lenLegal) begin
          r_pat  <= pat_value;
          r_len  <= pat_len;
          r_fill <= '0;
        end else begin
          r_cfgErr <= 1'b1;
        end
      end else if (inp_valid) begin
        r_hist <= w_histNext;
        r_fill <= (w_match && !overlap) ? '0 : w_fillInc;
      end
    end
  end

  assign seq_seen = r_seqSeen;
  assign cfg_err  = r_cfgErr;

`ifdef SEQ_DETECT_PROG_CNT_EN
  logic [CNT_W-1:0] r_matchCount;

  // Saturating match counter; a clear in the same cycle as a match wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_matchCount <= '0;
    end else if (cnt_clr) begin
      r_matchCount <= '0;
    end else if (w_match && (r_matchCount != {CNT_W{1'b1}})) begin
      r_matchCount <= r_matchCount + CNT_W'(1);
    end
  end

  assign match_count = r_matchCount;
`else
  logic w_unusedCntClr;
  assign w_unusedCntClr = cnt_clr;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed testbench for seq_detect_prog (MAX_LEN=8, default pattern 1011,
// CNT_W=2 so counter saturation is reachable when SEQ_DETECT_PROG_CNT_EN is set).
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_W   = 2;

  logic               clk;
  logic               reset_n;
  logic               inp_bit;
  logic               inp_valid;
  logic               overlap;
  logic               pat_load;
  logic [MAX_LEN-1:0] pat_value;
  logic [LEN_W-1:0]   pat_len;
  logic               cnt_clr;
  logic               seq_seen;
  logic               cfg_err;
`ifdef SEQ_DETECT_PROG_CNT_EN
  logic [CNT_W-1:0]   match_count;
`endif

  int checks = 0;
  int errors = 0;

  seq_detect_prog #(
    .MAX_LEN(MAX_LEN),
    .DEF_LEN(4),
    .DEF_PAT(8'b0000_1011),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .inp_bit(inp_bit),
    .inp_valid(inp_valid),
    .overlap(overlap),
    .pat_load(pat_load),
    .pat_value(pat_value),
    .pat_len(pat_len),
    .cnt_clr(cnt_clr),
    .seq_seen(seq_seen),
    .cfg_err(cfg_err)
`ifdef SEQ_DETECT_PROG_CNT_EN
    ,
    .match_count(match_count)
`endif
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of serial input and return just after the active edge
  task automatic applyStimulus(input logic b, input logic v, input logic clr);
    @(negedge clk);
    inp_bit   = b;
    inp_valid = v;
    pat_load  = 1'b0;
    cnt_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  // Present one pattern load strobe together with an input bit
  task automatic loadPattern(input logic [MAX_LEN-1:0] val, input logic [LEN_W-1:0] len,
                             input logic b);
    @(negedge clk);
    inp_bit   = b;
    inp_valid = 1'b1;
    pat_load  = 1'b1;
    pat_value = val;
    pat_len   = len;
    cnt_clr   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Hold reset over a couple of edges and release on a falling edge
  task automatic doReset();
    @(negedge clk);
    reset_n   = 1'b0;
    inp_bit   = 1'b0;
    inp_valid = 1'b0;
    pat_load  = 1'b0;
    cnt_clr   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++;
    if (seq_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_seq_seen: got %b expected 0", seq_seen);
    end
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_cfg_err: got %b expected 0", cfg_err);
    end
`ifdef SEQ_DETECT_PROG_CNT_EN
    checks++;
    if (match_count !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_match_count: got %0d expected 0", match_count);
    end
`endif
    doReset();
  endtask

  task automatic test_overlap();
    logic [6:0] bits;
    logic [6:0] expSeen;
    bits    = 7'b1011011;
    expSeen = 7'b0001001;
    doReset();
    overlap = 1'b1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(bits[6-i], 1'b1, 1'b0);
      checks++;
      if (seq_seen !== expSeen[6-i]) begin
        errors++;
        $display("[TB] FAIL overlap_bit%0d: seq_seen got %b expected %b", i + 1, seq_seen, expSeen[6-i]);
      end
    end
`ifdef SEQ_DETECT_PROG_CNT_EN
    checks++;
    if (match_count !== 2'd2) begin
      errors++;
      $display("[TB] FAIL overlap_count: got %0d expected 2", match_count);
    end
`endif
  endtask

  task automatic test_nonoverlap();
    logic [6:0] bits;
    logic [6:0] expSeen;
    bits    = 7'b1011011;
    expSeen = 7'b0001000;
    doReset();
    overlap = 1'b0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(bits[6-i], 1'b1, 1'b0);
      checks++;
      if (seq_seen !== expSeen[6-i]) begin
        errors++;
        $display("[TB] FAIL nonoverlap_bit%0d: seq_seen got %b expected %b", i + 1, seq_seen, expSeen[6-i]);
      end
    end
`ifdef SEQ_DETECT_PROG_CNT_EN
    checks++;
    if (match_count !== 2'd1) begin
      errors++;
      $display("[TB] FAIL nonoverlap_count: got %0d expected 1", match_count);
    end
`endif
  endtask

  task automatic test_valid_gaps();
    logic [3:0] bits;
    logic       expSeen;
    bits = 4'b1011;
    doReset();
    overlap = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(bits[3-i], 1'b1, 1'b0);
      expSeen = (i == 3);
      checks++;
      if (seq_seen !== expSeen) begin
        errors++;
        $display("[TB] FAIL gaps_bit%0d: seq_seen got %b expected %b", i + 1, seq_seen, expSeen);
      end
      for (int g = 0; g < 3; g++) begin
        applyStimulus(1'b1, 1'b0, 1'b0);
        checks++;
        if (seq_seen !== 1'b0) begin
          errors++;
          $display("[TB] FAIL gaps_idle%0d_%0d: seq_seen got %b expected 0", i + 1, g, seq_seen);
        end
      end
    end
  endtask

  task automatic test_load();
    logic [5:0] bits;
    logic [5:0] expSeen;
    logic [2:0] tail;
    logic [2:0] expTail;
    bits    = 6'b110110;
    expSeen = 6'b000001;
    tail    = 3'b110;
    expTail = 3'b001;
    doReset();
    overlap = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    loadPattern(8'b0011_0110, LEN_W'(6), 1'b1);
    checks++;
    if (seq_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_cycle: seq_seen got %b expected 0", seq_seen);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(bits[5-i], 1'b1, 1'b0);
      checks++;
      if (seq_seen !== expSeen[5-i]) begin
        errors++;
        $display("[TB] FAIL load_bit%0d: seq_seen got %b expected %b", i + 1, seq_seen, expSeen[5-i]);
      end
    end
    loadPattern(8'b1111_1111, LEN_W'(9), 1'b1);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL illegal_len_err: cfg_err got %b expected 1", cfg_err);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(tail[2-i], 1'b1, 1'b0);
      checks++;
      if (seq_seen !== expTail[2-i]) begin
        errors++;
        $display("[TB] FAIL illegal_keep_bit%0d: seq_seen got %b expected %b", i + 1, seq_seen, expTail[2-i]);
      end
    end
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cfg_err_sticky: got %b expected 1", cfg_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] expSeen;
`ifdef SEQ_DETECT_PROG_CNT_EN
    logic [1:0] expCnt [6];
    expCnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`endif
    expSeen = 6'b011111;
    doReset();
    overlap = 1'b1;
    loadPattern(8'b0000_0011, LEN_W'(2), 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checks++;
      if (seq_seen !== expSeen[5-i]) begin
        errors++;
        $display("[TB] FAIL b2b_bit%0d: seq_seen got %b expected %b", i + 1, seq_seen, expSeen[5-i]);
      end
`ifdef SEQ_DETECT_PROG_CNT_EN
      checks++;
      if (match_count !== expCnt[i]) begin
        errors++;
        $display("[TB] FAIL sat_count_bit%0d: got %0d expected %0d", i + 1, match_count, expCnt[i]);
      end
`endif
    end
    applyStimulus(1'b1, 1'b1, 1'b1);
    checks++;
    if (seq_seen !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_match_seen: got %b expected 1", seq_seen);
    end
`ifdef SEQ_DETECT_PROG_CNT_EN
    checks++;
    if (match_count !== 2'd0) begin
      errors++;
      $display("[TB] FAIL clr_wins: got %0d expected 0", match_count);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [3:0] bits;
    logic [3:0] expSeen;
    bits    = 4'b1011;
    expSeen = 4'b0001;
    doReset();
    overlap = 1'b1;
    loadPattern(8'b0000_0000, LEN_W'(0), 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checks++;
    if (seq_seen !== 1'b1 || cfg_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset: seq_seen/cfg_err got %b/%b expected 1/1", seq_seen, cfg_err);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (seq_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_seen: got %b expected 0", seq_seen);
    end
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_err: got %b expected 0", cfg_err);
    end
`ifdef SEQ_DETECT_PROG_CNT_EN
    checks++;
    if (match_count !== 2'd0) begin
      errors++;
      $display("[TB] FAIL async_reset_count: got %0d expected 0", match_count);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checks++;
    if (seq_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_first: seq_seen got %b expected 0", seq_seen);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(bits[3-i], 1'b1, 1'b0);
      checks++;
      if (seq_seen !== expSeen[3-i]) begin
        errors++;
        $display("[TB] FAIL post_reset_bit%0d: seq_seen got %b expected %b", i + 1, seq_seen, expSeen[3-i]);
      end
    end
  endtask

  // Run every scenario in order and report the totals
  initial begin
    reset_n   = 1'b0;
    inp_bit   = 1'b0;
    inp_valid = 1'b0;
    overlap   = 1'b1;
    pat_load  = 1'b0;
    pat_value = '0;
    pat_len   = '0;
    cnt_clr   = 1'b0;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_valid_gaps();
    test_load();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Runtime-programmable serial bit-pattern detector, the parametrised successor to the fixed 4-bit detector. It detects patterns of up to `MAX_LEN` bits, with the pattern and length loadable at run time, a valid-qualified input, a selectable overlapping or non-overlapping mode, and an optional saturating match counter. It sits on the same single-bit serial input paths, between the bit-recovery logic and the control/interrupt logic that consumes `seq_seen`.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits; legal range 2..16.
- `DEF_LEN`, 4: pattern length after reset; legal range 1..`MAX_LEN`.
- `DEF_PAT`, 8'b0000_1011: pattern after reset; right-aligned, lower `DEF_LEN` bits used.
- `CNT_W`, 8: match counter width.

- `clk`  in  1  clock; rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `inp_bit`  in  1  serial data bit.
- `inp_valid`  in  1  `inp_bit` is sampled only when high.
- `overlap`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `pat_load`  in  1  single-cycle strobe that loads `pat_value` and `pat_len`.
- `pat_value`  in  `MAX_LEN`  new pattern, right-aligned. The MSB of the used field is the first bit received.
- `pat_len`  in  `$clog2(MAX_LEN+1)`  new length; legal range 1..`MAX_LEN`.
- `cnt_clr`  in  1  synchronous clear of `match_count`.
- `seq_seen`  out  1  registered match pulse.
- `match_count`  out  `CNT_W`  saturating match count. Present only when the counter is configured in (see Configuration).
- `cfg_err`  out  1  sticky flag: an illegal `pat_len` was presented with `pat_load`.

## Operation
- **State:**
  - `hist`: `MAX_LEN`-bit shift register. The newest bit is at bit 0.
  - `fill`: count of valid history bits, saturating at `MAX_LEN`.
  - `pat`, `len`: the active pattern and length.
- **Accepted bit** (`inp_valid`=1, `pat_load`=0):
  - `hist <= {hist[MAX_LEN-2:0], inp_bit}`.
  - `fill` increments, saturating.
- **Match condition** is evaluated combinationally on the post-shift values:
  - `fill_next >= len`, and
  - the lower `len` bits of `hist_next` equal the lower `len` bits of `pat`.
- **On a match:**
  - `seq_seen` is 1 in the following cycle.
  - Overlap mode: `fill` is kept, so history bits are reused by later matches.
  - Non-overlap mode: `fill` is forced to 0 in the same update. No bit of a matched occurrence contributes to a later match.
- **Idle cycle** (`inp_valid`=0): `hist` and `fill` hold, and `seq_seen` is 0 in the next cycle.
- **Pattern load** (`pat_load`=1, legal `pat_len`):
  - `pat` and `len` are updated.
  - `fill` is cleared to 0.
  - `inp_bit` is discarded that cycle, even if `inp_valid`=1.
  - No match can be reported from that cycle.
- **Illegal load** (`pat_len`=0 or `pat_len`>`MAX_LEN`):
  - `pat`, `len` and `fill` are unchanged.
  - The input bit is still discarded.
  - `cfg_err` is set to 1 and stays set until reset.
- **Mode change:** `overlap` is sampled every cycle. A change applies from the next accepted bit; history is not cleared.
- **Reset values:**
  - `seq_seen`=0, `match_count`=0, `cfg_err`=0.
  - `hist`=0, `fill`=0.
  - `pat`=`DEF_PAT`, `len`=`DEF_LEN`.

## Timing
- Latency: `seq_seen` rises in the cycle after the rising edge that accepts the final pattern bit, and lasts exactly one cycle per match.
- Back-to-back matches:
  - With overlap and a self-overlapping pattern, `seq_seen` can be high on consecutive cycles.
  - Example: pattern `11`, len 2, continuous 1s give `seq_seen` high on every cycle from the second bit onward.
- `match_count` updates on the same edge as `seq_seen`.
- `reset_n` asserted mid-sequence: all state returns to reset values immediately, without waiting for a clock edge. Partial history is lost.
- The first bit accepted after `reset_n` deasserts is treated as bit 1 of a new sequence.

## Configuration
- Macro: `SEQ_DETECT_PROG_CNT_EN`.
- **Defined:**
  - The `match_count` port and the `cnt_clr` logic exist.
  - The counter increments on every match and saturates at 2^`CNT_W`−1.
  - When `cnt_clr` and a match occur in the same cycle, the clear wins and the result is 0.
- **Undefined:**
  - The `match_count` port is absent and no counter flops are built.
  - `cnt_clr` is still a port but is ignored.
  - All other behaviour is identical.

## Test plan
- **Default pattern, overlap:** reset, `overlap`=1, `inp_valid`=1, bits 1,0,1,1,0,1,1 → `seq_seen` high in the cycles after bits 4 and 7 only. With the counter enabled, `match_count`=2.
- **Default pattern, non-overlap:** same stream with `overlap`=0 → `seq_seen` high only after bit 4; `match_count`=1.
- **Valid gaps:** bits 1,0,1,1 with `inp_valid`=0 for 3 cycles between each bit → exactly one `seq_seen` pulse, one cycle after the 4th accepted bit.
- **Load mid-stream:**
  - Feed 1,0,1, then `pat_load` with `pat_value`=8'b0011_0110, `pat_len`=6 and `inp_bit`=1 in the same cycle → that 1 is discarded.
  - Then feed 1,1,0,1,1,0 → a single pulse after the 6th bit.
  - Then `pat_len`=9 with `MAX_LEN`=8 → `cfg_err`=1 and the pattern is unchanged.
- **Saturation and clear:**
  - `CNT_W`=2, pattern `11` len 2, six 1s in overlap mode → 5 matches and `match_count`=3.
  - Then `cnt_clr` on the same cycle as a match → `match_count`=0.
- **Reset mid-operation:** after bits 1,0,1, assert `reset_n`=0 between clock edges → `seq_seen`, `fill` and `cfg_err` are cleared immediately. After release, bit 1 alone produces no pulse; 1,0,1,1 then produces one pulse.
